// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the immediate-decode stage.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_FENCE   = 7'b0001111;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;

  // Immediate is kept beside the entry because its width follows XLEN.
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    imm_fmt_e    fmt;
    logic        illegal;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{valid: 1'b0, instr: '0, fmt: FMT_NONE, illegal: 1'b0};

endpackage

// File: rtl/imm_extract.sv
// Combinational opcode classification and sign-extended immediate assembly.
module imm_extract
  import imm_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter bit          EN_OP32 = 1'b0
) (
  input  logic [31:0]     instr,
  output imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [31:0] imm32;

  always_comb begin
    fmt = FMT_NONE;
    case (instr[6:0])
      OPC_LUI, OPC_AUIPC: fmt = FMT_U;
      OPC_JAL:            fmt = FMT_J;
      OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_SYSTEM, OPC_FENCE: fmt = FMT_I;
      OPC_OPIMM32:        if (EN_OP32) fmt = FMT_I;
      OPC_STORE:          fmt = FMT_S;
      OPC_BRANCH:         fmt = FMT_B;
      OPC_OP:             fmt = FMT_R;
      OPC_OP32:           if (EN_OP32) fmt = FMT_R;
      default:            fmt = FMT_NONE;
    endcase
    illegal = (fmt == FMT_NONE);

    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage: decode before capture, main + skid register, FIFO order.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter bit          EN_OP32 = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  entry_t          main_q, main_d, skid_q, skid_d, new_e;
  logic [XLEN-1:0] main_imm_q, main_imm_d, skid_imm_q, skid_imm_d, new_imm;
  logic            in_ready_q, in_ready_d;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;
  logic            accept, emit;

  imm_extract #(
    .XLEN    (XLEN),
    .EN_OP32 (EN_OP32)
  ) u_extract (
    .instr   (in_instr),
    .fmt     (dec_fmt),
    .imm     (new_imm),
    .illegal (dec_illegal)
  );

  assign accept = in_valid && in_ready_q;
  assign emit   = main_q.valid && out_ready;

  always_comb begin
    new_e      = '{valid: 1'b1, instr: in_instr, fmt: dec_fmt, illegal: dec_illegal};
    main_d     = main_q;
    main_imm_d = main_imm_q;
    skid_d     = skid_q;
    skid_imm_d = skid_imm_q;

    if (flush) begin
      main_d.valid = 1'b0;
      skid_d.valid = 1'b0;
    end else if (emit || !main_q.valid) begin
      // Main slot frees this cycle: the older skid entry advances first to keep FIFO order.
      if (skid_q.valid) begin
        main_d       = skid_q;
        main_imm_d   = skid_imm_q;
        skid_d.valid = 1'b0;
        if (accept) begin
          skid_d     = new_e;
          skid_imm_d = new_imm;
        end
      end else if (accept) begin
        main_d     = new_e;
        main_imm_d = new_imm;
      end else begin
        main_d.valid = 1'b0;
      end
    end else if (accept) begin
      skid_d     = new_e;
      skid_imm_d = new_imm;
    end

    in_ready_d = !skid_d.valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= ENTRY_RESET;
      skid_q     <= ENTRY_RESET;
      main_imm_q <= '0;
      skid_imm_q <= '0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_imm_q <= main_imm_d;
      skid_imm_q <= skid_imm_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_q.valid;
  assign out_instr   = main_q.instr;
  assign out_imm     = main_imm_q;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Random and directed bench for imm_decode_stage, three parameterisations sharing one stimulus.
module tb_imm_decode_stage;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;

  logic        a_ir, a_ov, a_il;
  logic [31:0] a_oi;
  logic [31:0] a_imm;
  logic [2:0]  a_f;
  logic        b_ir, b_ov, b_il;
  logic [31:0] b_oi;
  logic [63:0] b_imm;
  logic [2:0]  b_f;
  logic        c_ir, c_ov, c_il;
  logic [31:0] c_oi;
  logic [63:0] c_imm;
  logic [2:0]  c_f;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .EN_OP32(1'b0)) d32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_ir),
    .in_instr(in_instr), .out_valid(a_ov), .out_ready(out_ready), .out_instr(a_oi),
    .out_imm(a_imm), .out_fmt(a_f), .out_illegal(a_il));

  imm_decode_stage #(.XLEN(64), .EN_OP32(1'b0)) d64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_ir),
    .in_instr(in_instr), .out_valid(b_ov), .out_ready(out_ready), .out_instr(b_oi),
    .out_imm(b_imm), .out_fmt(b_f), .out_illegal(b_il));

  imm_decode_stage #(.XLEN(64), .EN_OP32(1'b1)) d64e (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(c_ir),
    .in_instr(in_instr), .out_valid(c_ov), .out_ready(out_ready), .out_instr(c_oi),
    .out_imm(c_imm), .out_fmt(c_f), .out_illegal(c_il));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference decode straight from the ISA field layout, using 64-bit signed arithmetic.
  function automatic void ref_decode(input logic [31:0] i, input bit op32,
                                     output logic [2:0] f, output logic [63:0] imm);
    longint s, v;
    logic [6:0] op;
    op = i[6:0];
    s  = longint'($signed(i));
    if (op == 7'b0110111 || op == 7'b0010111) f = FMT_U;
    else if (op == 7'b1101111) f = FMT_J;
    else if (op inside {7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011, 7'b0001111}) f = FMT_I;
    else if (op == 7'b0011011 && op32) f = FMT_I;
    else if (op == 7'b0100011) f = FMT_S;
    else if (op == 7'b1100011) f = FMT_B;
    else if (op == 7'b0110011 || (op == 7'b0111011 && op32)) f = FMT_R;
    else f = FMT_NONE;
    case (f)
      FMT_I: v = s >>> 20;
      FMT_S: v = ((s >>> 25) <<< 5) | longint'(i[11:7]);
      FMT_B: v = ((s >>> 31) <<< 12) | (longint'(i[7]) << 11) | (longint'(i[30:25]) << 5)
                 | (longint'(i[11:8]) << 1);
      FMT_J: v = ((s >>> 31) <<< 20) | (longint'(i[19:12]) << 12) | (longint'(i[20]) << 11)
                 | (longint'(i[30:21]) << 1);
      FMT_U: v = (s >>> 12) <<< 12;
      default: v = 0;
    endcase
    imm = v;
  endfunction

  task automatic check_dut(input string n, input bit op32, input bit is32, input logic ir,
                           input logic ov, input logic [31:0] oi, input logic [63:0] imm,
                           input logic [2:0] f, input logic il);
    logic [2:0]  ef;
    logic [63:0] eimm;
    chk({n, ".in_ready"}, 64'(ir), 64'(q.size() < 2));
    chk({n, ".out_valid"}, 64'(ov), 64'(q.size() > 0));
    if (q.size() > 0) begin
      ref_decode(q[0], op32, ef, eimm);
      if (is32) eimm[63:32] = '0;
      chk({n, ".instr"}, 64'(oi), 64'(q[0]));
      chk({n, ".fmt"}, 64'(f), 64'(ef));
      chk({n, ".imm"}, imm, eimm);
      chk({n, ".illegal"}, 64'(il), 64'(ef == FMT_NONE));
    end
  endtask

  task automatic check_all();
    check_dut("d32", 1'b0, 1'b1, a_ir, a_ov, a_oi, {32'b0, a_imm}, a_f, a_il);
    check_dut("d64", 1'b0, 1'b0, b_ir, b_ov, b_oi, b_imm, b_f, b_il);
    check_dut("d64e", 1'b1, 1'b0, c_ir, c_ov, c_oi, c_imm, c_f, c_il);
  endtask

  // One clock: model advances from the inputs present at the edge, then outputs are checked.
  task automatic cycle();
    bit acc, emt;
    acc = in_valid && (q.size() < 2);
    emt = out_ready && (q.size() > 0);
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (emt) void'(q.pop_front());
      if (acc) q.push_back(in_instr);
    end
    #1;
    check_all();
  endtask

  task automatic send(input logic [31:0] instr);
    in_valid  = 1'b1;
    in_instr  = instr;
    out_ready = 1'b1;
    flush     = 1'b0;
    cycle();
    in_valid  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string n);
    chk({n, ".rst_ov"}, 64'(a_ov | b_ov | c_ov), 64'd0);
    chk({n, ".rst_ir"}, 64'(a_ir & b_ir & c_ir), 64'd1);
    chk({n, ".rst_fmt"}, 64'(b_f), 64'(FMT_NONE));
    chk({n, ".rst_instr"}, 64'(a_oi), 64'd0);
    chk({n, ".rst_imm"}, b_imm, 64'd0);
    chk({n, ".rst_ill"}, 64'(a_il), 64'd0);
  endtask

  logic [31:0] stream[4] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123450B7};
  logic [6:0]  ops[15] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
                           7'b0010011, 7'b0011011, 7'b1110011, 7'b0001111, 7'b0100011,
                           7'b1100011, 7'b0110011, 7'b0111011, 7'b1111111, 7'b0000000};

  initial begin
    int unsigned k;
    logic [31:0] r;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("init");
    rst_n = 1'b1;

    send(32'hFFF00093);
    chk("addi_imm", 64'(a_imm), 64'h0000_0000_FFFF_FFFF);
    chk("addi_fmt", 64'(a_f), 64'(FMT_I));
    send(32'hFE112E23);
    chk("sw_imm", 64'(a_imm), 64'h0000_0000_FFFF_FFFC);
    chk("sw_fmt", 64'(a_f), 64'(FMT_S));
    send(32'hFE000CE3);
    chk("beq_imm", 64'(a_imm), 64'h0000_0000_FFFF_FFF8);
    chk("beq_fmt", 64'(a_f), 64'(FMT_B));
    send(32'h123450B7);
    chk("lui_imm", 64'(a_imm), 64'h0000_0000_1234_5000);
    chk("lui_fmt", 64'(a_f), 64'(FMT_U));
    send(32'h800000B7);
    chk("lui64_imm", b_imm, 64'hFFFF_FFFF_8000_0000);
    send(32'h0000001B);
    chk("op32_ill", 64'(b_il), 64'd1);
    chk("op32_fmt", 64'(b_f), 64'(FMT_NONE));
    chk("op32_imm", b_imm, 64'd0);
    chk("op32e_fmt", 64'(c_f), 64'(FMT_I));
    out_ready = 1'b1;
    cycle();

    // Four-instruction stream against a stalled consumer, then released.
    out_ready = 1'b0;
    k = 0;
    for (int n = 0; n < 30 && (k < 4 || q.size() > 0); n++) begin
      if (n == 5) out_ready = 1'b1;
      in_valid = (k < 4);
      in_instr = stream[k % 4];
      if (in_valid && q.size() < 2) k++;
      cycle();
      if (n == 2) chk("stall_in_ready", 64'(a_ir), 64'd0);
    end
    in_valid = 1'b0;
    chk("stream_done", 64'(k), 64'd4);

    // Fill both registers, then flush with a live input.
    out_ready = 1'b0;
    send(32'h00100093); out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00200113; cycle();
    chk("full_in_ready", 64'(a_ir), 64'd0);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00300193; cycle();
    chk("flush_ov", 64'(a_ov), 64'd0);
    chk("flush_ir", 64'(a_ir), 64'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) cycle();

    // Reset asserted mid-stream, observed between clock edges.
    send(32'h00400213); out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00500293; cycle();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(32'hFFF00093);
    chk("post_rst_ov", 64'(a_ov), 64'd1);

    // Randomised traffic with occasional flushes.
    for (int n = 0; n < 600; n++) begin
      r = $urandom();
      if ($urandom_range(9) < 8) r[6:0] = ops[$urandom_range(14)];
      in_instr  = r;
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(9) < 6);
      flush     = ($urandom_range(39) == 0);
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
